// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: opcode, funct and request-kind definitions shared by the instruction encoder
package instr_encoder_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [2:0] {
        K_ADD = 3'd0,
        K_SUB = 3'd1,
        K_AND = 3'd2,
        K_OR  = 3'd3,
        K_LD  = 3'd4,
        K_SD  = 3'd5,
        K_BEQ = 3'd6,
        K_RSV = 3'd7
    } req_kind_e;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

endpackage

// File: rtl/instr_fifo2.sv
// instr_fifo2: 2-entry instruction word buffer with a registered not-full ready
module instr_fifo2
    import instr_encoder_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_data
);

    logic [INSTR_W-1:0] mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic [1:0]         next_count;
    logic               push;
    logic               pop;

    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign out_valid  = count != 2'd0;
    assign out_data   = mem[rd_ptr];
    assign next_count = count + 2'(push) - 2'(pop);

    // Storage, pointers and occupancy; ready is registered from next occupancy so it never depends on out_ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            in_ready <= 1'b1;
        end else begin
            if (push)
                mem[wr_ptr] <= in_data;
            wr_ptr   <= wr_ptr ^ push;
            rd_ptr   <= rd_ptr ^ pop;
            count    <= next_count;
            in_ready <= next_count != 2'd2;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: assembles RV64 instruction words from symbolic requests; INSTR_ENCODER_CHECK_EN enables illegal-request checking
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_kind,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [12:0]       req_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              err
);

    req_kind_e          kind;
    logic [INSTR_W-1:0] word;
    logic               legal;

    assign kind = req_kind_e'(req_kind);

    // Assemble the instruction word for the current request, fields in standard RV positions
    always_comb begin
        word = '0;
        case (kind)
            K_ADD:   word = {F7_BASE, req_rs2, req_rs1, F3_ADD, req_rd, OP_R};
            K_SUB:   word = {F7_SUB, req_rs2, req_rs1, F3_ADD, req_rd, OP_R};
            K_AND:   word = {F7_BASE, req_rs2, req_rs1, F3_AND, req_rd, OP_R};
            K_OR:    word = {F7_BASE, req_rs2, req_rs1, F3_OR, req_rd, OP_R};
            K_LD:    word = {req_imm[11:0], req_rs1, F3_D, req_rd, OP_LD};
            K_SD:    word = {req_imm[11:5], req_rs2, req_rs1, F3_D, req_imm[4:0], OP_SD};
            K_BEQ:   word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, F3_BEQ,
                             req_imm[4:1], req_imm[11], OP_BEQ};
            default: word = '0;
        endcase
    end

`ifdef INSTR_ENCODER_CHECK_EN
    assign legal = (kind != K_RSV)
                && !((kind == K_LD || kind == K_SD) && (req_imm[12] != req_imm[11]))
                && !(kind == K_BEQ && req_imm[0]);

    // Sticky flag: an accepted illegal request is swallowed and remembered until reset
    always_ff @(posedge clk) begin
        if (!rst_n)
            err <= 1'b0;
        else if (req_valid && req_ready && !legal)
            err <= 1'b1;
    end
`else
    logic unused_imm;

    assign legal      = 1'b1;
    assign err        = 1'b0;
    assign unused_imm = req_imm[0];
`endif

    instr_fifo2 u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (req_valid && legal),
        .in_ready  (req_ready),
        .in_data   (word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_instr)
    );

    // Address counter: reload wins over the post-handshake increment
    always_ff @(posedge clk) begin
        if (!rst_n)
            out_addr <= BASE_ADDR;
        else if (base_load)
            out_addr <= base_addr;
        else if (out_valid && out_ready)
            out_addr <= out_addr + ADDR_W'(4);
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed checks of instr_encoder against a queue-based reference model
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_kind;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [12:0] req_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        base_load;
    logic [31:0] base_addr;
    logic        err;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_addr;
    logic        exp_err;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_kind  (req_kind),
        .req_rd    (req_rd),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_imm   (req_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .base_load (base_load),
        .base_addr (base_addr),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_word(int unsigned f7, int unsigned f3,
                                           int unsigned rd, int unsigned rs1, int unsigned rs2);
        return 32'((f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33);
    endfunction

    function automatic logic [31:0] model_word(int unsigned k, int unsigned rd, int unsigned rs1,
                                               int unsigned rs2, int unsigned imm);
        case (k)
            0: return r_word(0, 0, rd, rs1, rs2);
            1: return r_word('h20, 0, rd, rs1, rs2);
            2: return r_word(0, 7, rd, rs1, rs2);
            3: return r_word(0, 6, rd, rs1, rs2);
            4: return 32'(((imm & 'hFFF) << 20) | (rs1 << 15) | (3 << 12) | (rd << 7) | 'h03);
            5: return 32'((((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (3 << 12)
                          | ((imm & 'h1F) << 7) | 'h23);
            6: return 32'((((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (rs2 << 20)
                          | (rs1 << 15) | (((imm >> 1) & 'hF) << 8) | (((imm >> 11) & 1) << 7) | 'h63);
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_legal(int unsigned k, int unsigned imm);
`ifdef INSTR_ENCODER_CHECK_EN
        if (k == 7) return 1'b0;
        if ((k == 4 || k == 5) && (((imm >> 12) & 1) != ((imm >> 11) & 1))) return 1'b0;
        if (k == 6 && (imm & 1) == 1) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // One clock: compare DUT against the model, advance the model, then step to #1 after the edge
    task automatic cycle();
        bit hs;
        bit acc;
        int size;
        size = exp_q.size();
        chk("out_valid", 32'(out_valid), 32'(size != 0));
        chk("req_ready", 32'(req_ready), 32'(size < 2));
        chk("err", 32'(err), 32'(exp_err));
        chk("out_addr", out_addr, exp_addr);
        if (size != 0)
            chk("out_instr", out_instr, exp_q[0]);
        if (!rst_n) begin
            exp_q.delete();
            exp_addr = 32'h0;
            exp_err  = 1'b0;
        end else begin
            hs  = out_ready && size != 0;
            acc = req_valid && size < 2;
            if (hs)
                void'(exp_q.pop_front());
            if (acc) begin
                if (model_legal(req_kind, req_imm))
                    exp_q.push_back(model_word(req_kind, req_rd, req_rs1, req_rs2, req_imm));
                else
                    exp_err = 1'b1;
            end
            if (base_load)
                exp_addr = base_addr;
            else if (hs)
                exp_addr = exp_addr + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int k, input int rd, input int rs1, input int rs2, input int imm);
        req_valid = 1'b1;
        req_kind  = 3'(k);
        req_rd    = 5'(rd);
        req_rs1   = 5'(rs1);
        req_rs2   = 5'(rs2);
        req_imm   = 13'(imm);
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        base_load = 1'b0;
        rst_n     = 1'b0;
        cycle();
        rst_n     = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_kind = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
        req_imm = '0; out_ready = 1'b0; base_load = 1'b0; base_addr = '0;
        exp_addr = 32'h0; exp_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_addr", out_addr, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        // add x3,x1,x2
        out_ready = 1'b1;
        issue(0, 3, 1, 2, 0);
        cycle();
        req_valid = 1'b0;
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_word", out_instr, 32'h002081B3);
        chk("add_addr", out_addr, 32'h0);
        cycle();

        // ld x5,8(x2) then sd x5,16(x2), back to back
        do_reset();
        out_ready = 1'b1;
        issue(4, 5, 2, 0, 8);
        cycle();
        issue(5, 0, 2, 5, 16);
        chk("ld_word", out_instr, 32'h00813283);
        chk("ld_addr", out_addr, 32'h0);
        cycle();
        req_valid = 1'b0;
        chk("sd_word", out_instr, 32'h00513823);
        chk("sd_addr", out_addr, 32'h4);
        cycle();

        // beq x1,x2,-4
        issue(6, 0, 1, 2, -4);
        cycle();
        req_valid = 1'b0;
        chk("beq_word", out_instr, 32'hFE208EE3);
        cycle();

        // back-pressure: third request stalls, words drain in order at 0,4,8
        do_reset();
        out_ready = 1'b0;
        issue(0, 1, 2, 3, 0);
        cycle();
        chk("bp_ready1", 32'(req_ready), 32'd1);
        issue(1, 4, 5, 6, 0);
        cycle();
        chk("bp_ready2", 32'(req_ready), 32'd0);
        issue(2, 7, 8, 9, 0);
        cycle();
        cycle();
        chk("bp_hold_addr", out_addr, 32'h0);
        out_ready = 1'b1;
        cycle();
        chk("bp_addr4", out_addr, 32'h4);
        cycle();
        req_valid = 1'b0;
        chk("bp_word3", out_instr, model_word(2, 7, 8, 9, 0));
        chk("bp_addr8", out_addr, 32'h8);
        cycle();

        // base_load coinciding with an output handshake
        do_reset();
        out_ready = 1'b1;
        issue(3, 1, 1, 1, 0);
        cycle();
        issue(0, 2, 2, 2, 0);
        base_load = 1'b1;
        base_addr = 32'h100;
        chk("bl_old_addr", out_addr, 32'h0);
        cycle();
        req_valid = 1'b0;
        base_load = 1'b0;
        chk("bl_new_addr", out_addr, 32'h100);
        cycle();

        // counter wraps modulo 2^32
        issue(0, 1, 1, 1, 0);
        base_load = 1'b1;
        base_addr = 32'hFFFF_FFFC;
        cycle();
        req_valid = 1'b0;
        base_load = 1'b0;
        cycle();
        chk("wrap_addr", out_addr, 32'h0);

        // reserved kind
        do_reset();
        out_ready = 1'b1;
        issue(7, 1, 2, 3, 0);
        cycle();
        req_valid = 1'b0;
`ifdef INSTR_ENCODER_CHECK_EN
        chk("k7_valid", 32'(out_valid), 32'd0);
        chk("k7_err", 32'(err), 32'd1);
        cycle();
        cycle();
        chk("k7_err_sticky", 32'(err), 32'd1);
`else
        chk("k7_valid", 32'(out_valid), 32'd1);
        chk("k7_word", out_instr, 32'h0);
        chk("k7_err", 32'(err), 32'd0);
        cycle();
`endif

        // reset mid-stream discards buffered words
        do_reset();
        out_ready = 1'b0;
        issue(0, 1, 1, 1, 0);
        cycle();
        cycle();
        req_valid = 1'b0;
        do_reset();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_addr", out_addr, 32'h0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            req_valid = $urandom_range(0, 3) != 0;
            req_kind  = 3'($urandom_range(0, 7));
            req_rd    = 5'($urandom);
            req_rs1   = 5'($urandom);
            req_rs2   = 5'($urandom);
            req_imm   = 13'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            base_load = $urandom_range(0, 24) == 0;
            base_addr = $urandom;
            cycle();
        end
        req_valid = 1'b0;
        base_load = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();
        chk("drain_empty", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
